// File: rtl/prl_rx_message_parser_mdo.sv
// PD protocol-layer RX parser: header/extended-header decode, multi-data-object capture and end-of-packet classification.
// Extended-message parsing is enabled by defining PRL_RX_EXT_MSG_EN.
module prl_rx_message_parser_mdo #(
  parameter int unsigned MAX_DO = 7,
  parameter int unsigned IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phy2prl_rx_packet_en,
  input  logic [2:0]       phy2prl_rx_packet_type,
  input  logic             phy2prl_rx_packet_done,
  input  logic [1:0]       phy2prl_rx_packet_result,
  input  logic [7:0]       phy2prl_rx_payload,
  input  logic             phy2prl_rx_payload_req,
  output logic             prl_rx_msg_req,
  output logic [2:0]       prl_rx_msg_result,
  output logic [1:0]       prl_rx_msg_type,
  output logic [2:0]       prl_rx_sop_type,
  output logic [4:0]       prl_rx_header_type,
  output logic [2:0]       prl_rx_message_id,
  output logic [2:0]       prl_rx_num_do,
  output logic [8:0]       prl_rx_ext_data_size,
  output logic             prl_rx_ext_chunked,
  input  logic [IDX_W-1:0] prl_rx_do_rd_idx,
  output logic [31:0]      prl_rx_do_rd_data,
  output logic             prl_rx_busy
);
  localparam int unsigned DO_W      = 32;
  localparam logic [2:0] RES_OK     = 3'd0;
  localparam logic [2:0] RES_TRUNC  = 3'd4;
  localparam logic [2:0] RES_LONG   = 3'd5;
  localparam logic [2:0] RES_NUM_DO = 3'd6;
  localparam logic [2:0] RES_UNSUP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
`ifdef PRL_RX_EXT_MSG_EN
    S_EXT_HDR,
`endif
    S_DATA,
    S_WAIT_DONE,
    S_DISCARD
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q;
  logic [2:0]       do_cnt_q;
  logic [2:0]       pend_q, pend_d;
  logic [23:0]      asm_q;
  logic [DO_W-1:0]  buf_q [MAX_DO];

  logic             pkt_start, byte_take, field_end, hdr_lat, wr_en;
  logic             mt_set, done_take, trunc;
  logic [1:0]       mt_d;
  logic [2:0]       res_d;
  logic [2:0]       hdr_nd;
  logic             hdr_ext;
`ifdef PRL_RX_EXT_MSG_EN
  logic             ext_lat;
`endif

  assign hdr_nd  = phy2prl_rx_payload[6:4];
  assign hdr_ext = phy2prl_rx_payload[7];

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pkt_start = 1'b0;
    byte_take = 1'b0;
    field_end = 1'b0;
    hdr_lat   = 1'b0;
    wr_en     = 1'b0;
    mt_set    = 1'b0;
    mt_d      = prl_rx_msg_type;
    done_take = 1'b0;
    res_d     = RES_OK;
    trunc     = 1'b0;
`ifdef PRL_RX_EXT_MSG_EN
    ext_lat   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (phy2prl_rx_packet_en) begin
          pkt_start = 1'b1;
          pend_d    = RES_OK;
          if (phy2prl_rx_packet_type < 3'd3) begin
            state_d = S_HDR;
          end else begin
            mt_set  = 1'b1;
            mt_d    = 2'd3;
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_HDR: begin
        if (phy2prl_rx_payload_req) begin
          byte_take = 1'b1;
          if (byte_cnt_q == 2'd1) begin
            field_end = 1'b1;
            hdr_lat   = 1'b1;
            if (32'(hdr_nd) > MAX_DO) begin
              state_d = S_DISCARD;
              pend_d  = RES_NUM_DO;
            end else if (hdr_ext) begin
              mt_set  = 1'b1;
              mt_d    = 2'd2;
`ifdef PRL_RX_EXT_MSG_EN
              state_d = S_EXT_HDR;
`else
              state_d = S_DISCARD;
              pend_d  = RES_UNSUP;
`endif
            end else if (hdr_nd != 3'd0) begin
              mt_set  = 1'b1;
              mt_d    = 2'd1;
              state_d = S_DATA;
            end else begin
              mt_set  = 1'b1;
              mt_d    = 2'd0;
              state_d = S_WAIT_DONE;
            end
          end
        end
      end
`ifdef PRL_RX_EXT_MSG_EN
      S_EXT_HDR: begin
        if (phy2prl_rx_payload_req) begin
          byte_take = 1'b1;
          if (byte_cnt_q == 2'd1) begin
            field_end = 1'b1;
            ext_lat   = 1'b1;
            state_d   = (prl_rx_num_do == 3'd0) ? S_WAIT_DONE : S_DATA;
          end
        end
      end
`endif
      S_DATA: begin
        if (phy2prl_rx_payload_req) begin
          byte_take = 1'b1;
          if (byte_cnt_q == 2'd3) begin
            field_end = 1'b1;
            wr_en     = 1'b1;
            if (do_cnt_q + 3'd1 == prl_rx_num_do) state_d = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (phy2prl_rx_payload_req) pend_d = RES_LONG;
      end
      S_DISCARD: state_d = state_q;
      default:   state_d = S_IDLE;
    endcase

    // Classification sees the state after any same-cycle byte has been consumed.
    trunc = (state_d == S_HDR) || (state_d == S_DATA);
`ifdef PRL_RX_EXT_MSG_EN
    trunc = trunc || (state_d == S_EXT_HDR);
`endif
    if ((state_q != S_IDLE) && phy2prl_rx_packet_done) begin
      done_take = 1'b1;
      if (phy2prl_rx_packet_result != 2'd0) res_d = {1'b0, phy2prl_rx_packet_result};
      else if (pend_d != RES_OK)            res_d = pend_d;
      else if (trunc)                       res_d = RES_TRUNC;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      byte_cnt_q         <= '0;
      do_cnt_q           <= '0;
      pend_q             <= '0;
      asm_q              <= '0;
      for (int i = 0; i < MAX_DO; i++) buf_q[i] <= '0;
      prl_rx_msg_req     <= 1'b0;
      prl_rx_msg_result  <= '0;
      prl_rx_msg_type    <= '0;
      prl_rx_sop_type    <= '0;
      prl_rx_header_type <= '0;
      prl_rx_message_id  <= '0;
      prl_rx_num_do      <= '0;
      prl_rx_busy        <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (pkt_start) begin
        byte_cnt_q      <= '0;
        do_cnt_q        <= '0;
        prl_rx_sop_type <= phy2prl_rx_packet_type;
      end else if (byte_take) begin
        byte_cnt_q <= field_end ? 2'd0 : byte_cnt_q + 2'd1;
      end
      if (byte_take) begin
        case (byte_cnt_q)
          2'd0:    asm_q[7:0]   <= phy2prl_rx_payload;
          2'd1:    asm_q[15:8]  <= phy2prl_rx_payload;
          2'd2:    asm_q[23:16] <= phy2prl_rx_payload;
          default: asm_q        <= asm_q;
        endcase
      end
      if (mt_set) prl_rx_msg_type <= mt_d;
      if (hdr_lat) begin
        prl_rx_header_type <= asm_q[4:0];
        prl_rx_message_id  <= phy2prl_rx_payload[3:1];
        prl_rx_num_do      <= hdr_nd;
      end
      if (wr_en) begin
        do_cnt_q <= do_cnt_q + 3'd1;
        for (int i = 0; i < MAX_DO; i++)
          if (do_cnt_q == 3'(i)) buf_q[i] <= {phy2prl_rx_payload, asm_q};
      end
      prl_rx_msg_req <= done_take;
      if (done_take) prl_rx_msg_result <= res_d;
      prl_rx_busy <= (state_d != S_IDLE);
    end
  end

`ifdef PRL_RX_EXT_MSG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prl_rx_ext_data_size <= '0;
      prl_rx_ext_chunked   <= 1'b0;
    end else if (ext_lat) begin
      prl_rx_ext_data_size <= {phy2prl_rx_payload[0], asm_q[7:0]};
      prl_rx_ext_chunked   <= phy2prl_rx_payload[7];
    end
  end
`else
  assign prl_rx_ext_data_size = '0;
  assign prl_rx_ext_chunked   = 1'b0;
`endif

  // Indexed read; slots beyond the announced count or the buffer depth read as zero.
  always_comb begin
    prl_rx_do_rd_data = '0;
    for (int i = 0; i < MAX_DO; i++)
      if ((prl_rx_do_rd_idx == IDX_W'(i)) && (3'(i) < prl_rx_num_do)) prl_rx_do_rd_data = buf_q[i];
  end
endmodule

// File: tb/tb_prl_rx_message_parser_mdo.sv
// Bench for prl_rx_message_parser_mdo: a packet-level model (bytes collected per packet, decoded at done) checks two instances (MAX_DO 7 and 2).
module tb_prl_rx_message_parser_mdo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] ptype = 3'd0;
  logic       done = 1'b0;
  logic [1:0] pres = 2'd0;
  logic [7:0] pay = 8'd0;
  logic       preq = 1'b0;
  logic [2:0] rd_idx = 3'd0;

  logic [1:0]       o_req, o_chunk, o_busy;
  logic [1:0][2:0]  o_res, o_sop, o_id, o_nd;
  logic [1:0][1:0]  o_mt;
  logic [1:0][4:0]  o_ht;
  logic [1:0][8:0]  o_es;
  logic [1:0][31:0] o_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prl_rx_message_parser_mdo dut (
    .clk(clk), .rst_n(rst_n),
    .phy2prl_rx_packet_en(en), .phy2prl_rx_packet_type(ptype),
    .phy2prl_rx_packet_done(done), .phy2prl_rx_packet_result(pres),
    .phy2prl_rx_payload(pay), .phy2prl_rx_payload_req(preq),
    .prl_rx_msg_req(o_req[0]), .prl_rx_msg_result(o_res[0]), .prl_rx_msg_type(o_mt[0]),
    .prl_rx_sop_type(o_sop[0]), .prl_rx_header_type(o_ht[0]), .prl_rx_message_id(o_id[0]),
    .prl_rx_num_do(o_nd[0]), .prl_rx_ext_data_size(o_es[0]), .prl_rx_ext_chunked(o_chunk[0]),
    .prl_rx_do_rd_idx(rd_idx), .prl_rx_do_rd_data(o_rd[0]), .prl_rx_busy(o_busy[0])
  );

  prl_rx_message_parser_mdo #(.MAX_DO(2), .IDX_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .phy2prl_rx_packet_en(en), .phy2prl_rx_packet_type(ptype),
    .phy2prl_rx_packet_done(done), .phy2prl_rx_packet_result(pres),
    .phy2prl_rx_payload(pay), .phy2prl_rx_payload_req(preq),
    .prl_rx_msg_req(o_req[1]), .prl_rx_msg_result(o_res[1]), .prl_rx_msg_type(o_mt[1]),
    .prl_rx_sop_type(o_sop[1]), .prl_rx_header_type(o_ht[1]), .prl_rx_message_id(o_id[1]),
    .prl_rx_num_do(o_nd[1]), .prl_rx_ext_data_size(o_es[1]), .prl_rx_ext_chunked(o_chunk[1]),
    .prl_rx_do_rd_idx(rd_idx), .prl_rx_do_rd_data(o_rd[1]), .prl_rx_busy(o_busy[1])
  );

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] @%0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  // Packet-level reference model
  bit          active;
  logic [7:0]  pkt[$];
  logic        e_req;
  logic [2:0]  e_res[2], e_sop[2], e_id[2], e_nd[2];
  logic [1:0]  e_mt[2];
  logic [4:0]  e_ht[2];
  logic [8:0]  e_es[2];
  logic        e_ch[2];
  logic [31:0] e_buf[2][8];

  function automatic int max_do(input int m);
    return (m == 0) ? 7 : 2;
  endfunction

  task automatic model_reset();
    active = 1'b0;
    pkt.delete();
    e_req = 1'b0;
    for (int m = 0; m < 2; m++) begin
      e_res[m] = '0; e_sop[m] = '0; e_id[m] = '0; e_nd[m] = '0;
      e_mt[m] = '0; e_ht[m] = '0; e_es[m] = '0; e_ch[m] = 1'b0;
      for (int i = 0; i < 8; i++) e_buf[m][i] = '0;
    end
  endtask

  task automatic data_code(input int m, input int s, input int nd, output logic [2:0] code);
    int avail;
    avail = pkt.size() - s;
    for (int i = 0; i < nd && 4 * i + 3 < avail; i++)
      e_buf[m][i] = {pkt[s+4*i+3], pkt[s+4*i+2], pkt[s+4*i+1], pkt[s+4*i]};
    if (avail < 4 * nd)      code = 3'd4;
    else if (avail > 4 * nd) code = 3'd5;
    else                     code = 3'd0;
  endtask

  task automatic finalize(input int m, input logic [1:0] phy, input logic [2:0] sop);
    logic [2:0]  code;
    logic [15:0] h;
    int          nd;
    code = 3'd0;
    if (sop >= 3'd3) begin
      code = (pkt.size() > 0) ? 3'd5 : 3'd0;
    end else if (pkt.size() < 2) begin
      code = 3'd4;
    end else begin
      h  = {pkt[1], pkt[0]};
      nd = int'(h[14:12]);
      e_ht[m] = h[4:0];
      e_id[m] = h[11:9];
      e_nd[m] = h[14:12];
      if (nd > max_do(m)) begin
        code = 3'd6;
      end else if (h[15]) begin
        e_mt[m] = 2'd2;
`ifdef PRL_RX_EXT_MSG_EN
        if (pkt.size() < 4) code = 3'd4;
        else begin
          e_es[m] = {pkt[3][0], pkt[2]};
          e_ch[m] = pkt[3][7];
          data_code(m, 4, nd, code);
        end
`else
        code = 3'd7;
`endif
      end else begin
        e_mt[m] = (nd != 0) ? 2'd1 : 2'd0;
        data_code(m, 2, nd, code);
      end
    end
    e_res[m] = (phy != 2'd0) ? {1'b0, phy} : code;
  endtask

  logic [2:0] m_sop;

  task automatic model_step();
    e_req = 1'b0;
    if (active) begin
      if (preq) pkt.push_back(pay);
      if (done) begin
        for (int m = 0; m < 2; m++) finalize(m, pres, m_sop);
        active = 1'b0;
        e_req  = 1'b1;
      end
    end else if (en) begin
      active = 1'b1;
      pkt.delete();
      m_sop = ptype;
      for (int m = 0; m < 2; m++) begin
        e_sop[m] = ptype;
        if (ptype >= 3'd3) e_mt[m] = 2'd3;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int m, input logic [2:0] idx);
    if (int'(idx) < int'(e_nd[m]) && int'(idx) < max_do(m)) return e_buf[m][idx];
    return 32'd0;
  endfunction

  // Cycle compare: pulse and busy always, stable fields whenever no packet is open.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("msg_req", m, 32'(o_req[m]), 32'(e_req));
      chk("busy", m, 32'(o_busy[m]), 32'(active));
      if (!active) begin
        chk("msg_result", m, 32'(o_res[m]), 32'(e_res[m]));
        chk("msg_type", m, 32'(o_mt[m]), 32'(e_mt[m]));
        chk("sop_type", m, 32'(o_sop[m]), 32'(e_sop[m]));
        chk("header_type", m, 32'(o_ht[m]), 32'(e_ht[m]));
        chk("message_id", m, 32'(o_id[m]), 32'(e_id[m]));
        chk("num_do", m, 32'(o_nd[m]), 32'(e_nd[m]));
        chk("ext_data_size", m, 32'(o_es[m]), 32'(e_es[m]));
        chk("ext_chunked", m, 32'(o_chunk[m]), 32'(e_ch[m]));
        chk("rd_data", m, o_rd[m], exp_rd(m, rd_idx));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    rd_idx = 3'($urandom);
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] b[$], input logic [1:0] r,
                      input bit same, input int gapmax, input bit stray);
    step(); en = 1'b1; ptype = t;
    step(); en = 1'b0; ptype = 3'($urandom);
    for (int i = 0; i < b.size(); i++) begin
      int g;
      g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
      repeat (g) step();
      pay = b[i]; preq = 1'b1;
      if (stray && i == 0) en = 1'b1;
      if (same && i == b.size() - 1) begin done = 1'b1; pres = r; end
      step(); preq = 1'b0; en = 1'b0; done = 1'b0; pay = 8'($urandom);
    end
    if (!(same && b.size() > 0)) begin
      done = 1'b1; pres = r;
      step(); done = 1'b0;
    end
    pres = 2'($urandom);
  endtask

  task automatic rd_chk(input string nm, input int m, input logic [2:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    chk(nm, m, o_rd[m], exp);
  endtask

  task automatic rand_pkt();
    logic [7:0] b[$];
    logic [7:0] h1;
    int kind, nd, base, n, sel;
    logic [2:0] t;
    logic [1:0] r;
    kind = $urandom_range(9, 0);
    if (kind == 0) begin
      t = 3'($urandom_range(7, 3));
      n = $urandom_range(1, 0);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    end else begin
      t  = 3'($urandom_range(2, 0));
      nd = $urandom_range(7, 0);
      h1 = {($urandom_range(3, 0) == 0), 3'(nd), 4'($urandom)};
      base = 2 + (h1[7] ? 2 : 0) + 4 * nd;
      sel = $urandom_range(9, 0);
      if (sel < 6)      n = base;
      else if (sel < 8) n = $urandom_range(base - 1, 0);
      else              n = base + $urandom_range(2, 1);
      for (int i = 0; i < n; i++) b.push_back((i == 1) ? h1 : 8'($urandom));
    end
    r = ($urandom_range(4, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
    if ($urandom_range(5, 0) == 0) begin
      done = 1'b1; step(); done = 1'b0;
    end
    send(t, b, r, $urandom_range(1, 0) == 1, $urandom_range(2, 0), $urandom_range(7, 0) == 0);
    repeat ($urandom_range(3, 1)) step();
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n = 1'b0;
    repeat (3) step();
    for (int m = 0; m < 2; m++) begin
      chk("rst_msg_req", m, 32'(o_req[m]), 32'd0);
      chk("rst_msg_result", m, 32'(o_res[m]), 32'd0);
      chk("rst_msg_type", m, 32'(o_mt[m]), 32'd0);
      chk("rst_num_do", m, 32'(o_nd[m]), 32'd0);
      chk("rst_busy", m, 32'(o_busy[m]), 32'd0);
      chk("rst_rd_data", m, o_rd[m], 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Four DOs announced: MAX_DO=2 instance discards, the other sees a truncation
    q.delete(); q.push_back(8'h46); q.push_back(8'h40);
    send(3'd0, q, 2'd0, 1'b0, 0, 1'b0);
    chk("nd4_req", 1, 32'(o_req[1]), 32'd1);
    chk("nd4_result_max2", 1, 32'(o_res[1]), 32'd6);
    chk("nd4_result_max7", 0, 32'(o_res[0]), 32'd4);
    chk("nd4_num_do", 1, 32'(o_nd[1]), 32'd4);
    for (int i = 0; i < 8; i++) rd_chk("nd4_rd_data", 1, 3'(i), 32'd0);

    // GoodCRC
    q.delete(); q.push_back(8'h41); q.push_back(8'h00);
    send(3'd0, q, 2'd0, 1'b0, 0, 1'b0);
    chk("goodcrc_req", 0, 32'(o_req[0]), 32'd1);
    chk("goodcrc_type", 0, 32'(o_mt[0]), 32'd0);
    chk("goodcrc_htype", 0, 32'(o_ht[0]), 32'd1);
    chk("goodcrc_num_do", 0, 32'(o_nd[0]), 32'd0);
    chk("goodcrc_result", 0, 32'(o_res[0]), 32'd0);
    step();
    chk("goodcrc_req_one_cycle", 0, 32'(o_req[0]), 32'd0);

    // Request with two data objects
    q.delete(); q.push_back(8'h42); q.push_back(8'h20);
    for (int i = 1; i <= 8; i++) q.push_back(8'(8'h11 * i));
    send(3'd1, q, 2'd0, 1'b1, 1, 1'b0);
    chk("req_type", 0, 32'(o_mt[0]), 32'd1);
    chk("req_num_do", 0, 32'(o_nd[0]), 32'd2);
    chk("req_result", 0, 32'(o_res[0]), 32'd0);
    chk("req_sop", 0, 32'(o_sop[0]), 32'd1);
    rd_chk("req_do0", 0, 3'd0, 32'h44332211);
    rd_chk("req_do1", 0, 3'd1, 32'h88776655);
    rd_chk("req_do2", 0, 3'd2, 32'd0);
    rd_chk("req_do1_max2", 1, 3'd1, 32'h88776655);

    // Three DOs announced, short then long
    q.delete(); q.push_back(8'h46); q.push_back(8'h30);
    for (int i = 0; i < 5; i++) q.push_back(8'(i + 1));
    send(3'd0, q, 2'd0, 1'b0, 0, 1'b0);
    chk("short_result", 0, 32'(o_res[0]), 32'd4);
    chk("short_result_max2", 1, 32'(o_res[1]), 32'd6);
    for (int i = 0; i < 8; i++) q.push_back(8'(i + 6));
    send(3'd0, q, 2'd0, 1'b0, 0, 1'b0);
    chk("long_result", 0, 32'(o_res[0]), 32'd5);

    // Extended header, one DO
    q.delete(); q.push_back(8'h1F); q.push_back(8'h90); q.push_back(8'h05); q.push_back(8'h80);
    q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3); q.push_back(8'hA4);
    send(3'd0, q, 2'd0, 1'b0, 0, 1'b0);
    chk("ext_type", 0, 32'(o_mt[0]), 32'd2);
    chk("ext_htype", 0, 32'(o_ht[0]), 32'h1F);
`ifdef PRL_RX_EXT_MSG_EN
    chk("ext_result", 0, 32'(o_res[0]), 32'd0);
    chk("ext_size", 0, 32'(o_es[0]), 32'd5);
    chk("ext_chunked", 0, 32'(o_chunk[0]), 32'd1);
    rd_chk("ext_do0", 0, 3'd0, 32'hA4A3A2A1);
`else
    chk("ext_result", 0, 32'(o_res[0]), 32'd7);
    chk("ext_size", 0, 32'(o_es[0]), 32'd0);
`endif

    // Signalling packet
    q.delete();
    send(3'd5, q, 2'd0, 1'b0, 0, 1'b0);
    chk("sig_req", 0, 32'(o_req[0]), 32'd1);
    chk("sig_type", 0, 32'(o_mt[0]), 32'd3);
    chk("sig_result", 0, 32'(o_res[0]), 32'd0);
    chk("sig_sop", 0, 32'(o_sop[0]), 32'd5);

    // PHY error overrides a good parse
    q.delete(); q.push_back(8'h41); q.push_back(8'h00);
    send(3'd0, q, 2'd2, 1'b1, 0, 1'b0);
    chk("phyerr_result", 0, 32'(o_res[0]), 32'd2);

    // Reset in the middle of a data object
    step(); en = 1'b1; ptype = 3'd0;
    step(); en = 1'b0;
    q.delete(); q.push_back(8'h42); q.push_back(8'h20); q.push_back(8'h11); q.push_back(8'h22);
    for (int i = 0; i < 4; i++) begin
      pay = q[i]; preq = 1'b1;
      step();
    end
    preq = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("midrst_num_do", 0, 32'(o_nd[0]), 32'd0);
    chk("midrst_type", 0, 32'(o_mt[0]), 32'd0);
    step(); step();
    rst_n = 1'b1;
    done = 1'b1;
    step(); done = 1'b0;
    step();
    chk("midrst_no_req", 0, 32'(o_req[0]), 32'd0);

    for (int k = 0; k < 300; k++) rand_pkt();

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
